exp_engine: RTL and testbench

Parametrised exponentiation engine computing a^n from a start pulse, with a done flag and a 16-bit-class result. It generalises the fixed 8/16-bit exponent datapaths: widths are parameters, and a per-request mode selects repeated multiplication or square-and-multiply. It also reports overflow and the multiply-cycle count so both algorithms can be compared inside one instance.

---
 rtl/exp_engine.sv | 170 +++++++++++++++++
 tb/tb_exp_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/exp_engine.sv
// -----------------------------------------------------------------------------
// exp_engine
//   Computes a^n for unsigned a, n after a start request. Each request picks
//   its algorithm: repeated multiplication (linear, n multiply cycles) or
//   right-to-left square-and-multiply (bit-length-of-n multiply cycles).
//   Reports overflow of the true mathematical result and the number of
//   multiply cycles used, so both algorithms can be compared in one instance.
//
//   Build option:
//     EXP_SATURATE_EN  defined    -> result_o = all ones whenever ovf is set
//                      undefined  -> result_o = a^n mod 2^OUT_W
//
//   Parameters:
//     IN_W   width of base and exponent
//     OUT_W  width of result (OUT_W >= IN_W)
//
//   Ports:
//     clk       system clock, rising edge
//     rst       asynchronous reset, active low
//     go_i      start request, sampled only in IDLE
//     a_i       base (unsigned)
//     n_i       exponent (unsigned)
//     mode_i    0 = linear, 1 = square-and-multiply
//     busy_o    computation in progress
//     done_o    result available, waiting for go_i to drop
//     result_o  a^n (wrapped or saturated)
//     ovf_o     true a^n >= 2^OUT_W
//     cycles_o  multiply cycles used by the last request
// -----------------------------------------------------------------------------
module exp_engine #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_i,
    input  logic [IN_W-1:0]  a_i,
    input  logic [IN_W-1:0]  n_i,
    input  logic             mode_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [OUT_W-1:0] result_o,
    output logic             ovf_o,
    output logic [IN_W-1:0]  cycles_o
);

    localparam int PW = 2 * OUT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] r_base;
    logic [IN_W-1:0]  r_e;
    logic [IN_W-1:0]  r_cycles;
    logic             r_mode;
    logic             r_ovf;
    logic             r_base_ovf;
    logic [OUT_W-1:0] r_result;
    logic             r_ovf_o;
    logic [IN_W-1:0]  r_cycles_o;

    logic [PW-1:0]    w_acc_prod;
    logic [PW-1:0]    w_sq_prod;
    logic             w_use_mul;
    logic [OUT_W-1:0] w_result_fin;

    // Full-width products; the upper halves are the overflow indicators.
    assign w_acc_prod = PW'(r_acc) * PW'(r_base);
    assign w_sq_prod  = PW'(r_base) * PW'(r_base);

    // Linear mode multiplies every step; square-and-multiply only on set bits.
    assign w_use_mul  = !r_mode || r_e[0];

`ifdef EXP_SATURATE_EN
    assign w_result_fin = r_ovf ? {OUT_W{1'b1}} : r_acc;
`else
    assign w_result_fin = r_acc;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (go_i)      w_state_nxt = S_RUN;
            S_RUN:  if (r_e == '0) w_state_nxt = S_DONE;
            // Holding go_i high parks here, so a held request never retriggers.
            S_DONE: if (!go_i)     w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_base     <= '0;
            r_e        <= '0;
            r_cycles   <= '0;
            r_mode     <= 1'b0;
            r_ovf      <= 1'b0;
            r_base_ovf <= 1'b0;
            r_result   <= '0;
            r_ovf_o    <= 1'b0;
            r_cycles_o <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go_i) begin
                        r_acc      <= OUT_W'(1);
                        r_base     <= OUT_W'(a_i);
                        r_e        <= n_i;
                        r_mode     <= mode_i;
                        r_cycles   <= '0;
                        r_ovf      <= 1'b0;
                        r_base_ovf <= 1'b0;
                        r_result   <= '0;
                        r_ovf_o    <= 1'b0;
                        r_cycles_o <= '0;
                    end
                end
                S_RUN: begin
                    if (r_e != '0) begin
                        r_cycles <= r_cycles + IN_W'(1);
                        if (w_use_mul) begin
                            r_acc <= w_acc_prod[OUT_W-1:0];
                            // An overflowed base folded into acc means the true
                            // result is already >= 2^OUT_W (base is never 0 then).
                            if (w_acc_prod[PW-1:OUT_W] != '0 || r_base_ovf)
                                r_ovf <= 1'b1;
                        end
                        if (r_mode) begin
                            r_base <= w_sq_prod[OUT_W-1:0];
                            // Harmless unless this base is multiplied in later.
                            if (w_sq_prod[PW-1:OUT_W] != '0)
                                r_base_ovf <= 1'b1;
                            r_e <= r_e >> 1;
                        end else begin
                            r_e <= r_e - IN_W'(1);
                        end
                    end else begin
                        r_result   <= w_result_fin;
                        r_ovf_o    <= r_ovf;
                        r_cycles_o <= r_cycles;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (r_state == S_RUN);
    assign done_o   = (r_state == S_DONE);
    assign result_o = r_result;
    assign ovf_o    = r_ovf_o;
    assign cycles_o = r_cycles_o;

endmodule

// File: tb/tb_exp_engine.sv
module tb_exp_engine;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;

`ifdef EXP_SATURATE_EN
    localparam logic [OUT_W-1:0] RES_2_16 = 16'hFFFF;
`else
    localparam logic [OUT_W-1:0] RES_2_16 = 16'h0000;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             go_i = 1'b0;
    logic [IN_W-1:0]  a_i = '0;
    logic [IN_W-1:0]  n_i = '0;
    logic             mode_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic [OUT_W-1:0] result_o;
    logic             ovf_o;
    logic [IN_W-1:0]  cycles_o;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_engine #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .go_i     (go_i),
        .a_i      (a_i),
        .n_i      (n_i),
        .mode_i   (mode_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .ovf_o    (ovf_o),
        .cycles_o (cycles_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0]  a;
        logic [IN_W-1:0]  n;
        logic             mode;
        logic [OUT_W-1:0] res;
        logic             ovf;
        int               cyc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: a^n from plain integer arithmetic. The true value is tracked
    // capped at 2^OUT_W (enough to decide overflow), the wrapped value mod 2^OUT_W.
    task automatic model(input int a, input int n, input int mode,
                         output logic [OUT_W-1:0] res, output logic ovf, output int cyc);
        longint capv = 1;
        longint modv = 1;
        longint lim  = longint'(1) << OUT_W;
        int     x    = n;
        int     bl   = 0;
        for (int i = 0; i < n; i++) begin
            capv = capv * a;
            if (capv > lim) capv = lim;
            modv = (modv * a) % lim;
        end
        while (x != 0) begin
            x = x >> 1;
            bl++;
        end
        ovf = (capv >= lim);
        cyc = (mode != 0) ? bl : n;
`ifdef EXP_SATURATE_EN
        res = ovf ? {OUT_W{1'b1}} : OUT_W'(modv);
`else
        res = OUT_W'(modv);
`endif
    endtask

    // One request with go_i pulsed; checks latency, outputs and return to IDLE.
    task automatic do_req(input logic [IN_W-1:0] a, input logic [IN_W-1:0] n, input logic m,
                          input logic [OUT_W-1:0] er, input logic eo, input int ec,
                          input string tag);
        int lat;
        @(negedge clk);
        a_i = a; n_i = n; mode_i = m; go_i = 1'b1;
        @(posedge clk); #1;
        go_i = 1'b0;
        // Input changes during RUN must be ignored.
        a_i = IN_W'($urandom); n_i = IN_W'($urandom); mode_i = 1'($urandom);
        chk({tag, ".busy_run"}, busy_o, 1);
        lat = 0;
        while (!done_o && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (busy_o && done_o) chk({tag, ".busy_and_done"}, 1, 0);
        end
        chk({tag, ".done"}, done_o, 1);
        chk({tag, ".latency"}, lat, ec + 1);
        chk({tag, ".busy_done"}, busy_o, 0);
        chk({tag, ".result"}, result_o, er);
        chk({tag, ".ovf"}, ovf_o, eo);
        chk({tag, ".cycles"}, cycles_o, ec);
        @(posedge clk); #1;
        chk({tag, ".idle_done"}, done_o, 0);
        chk({tag, ".held_result"}, result_o, er);
    endtask

    initial begin
        logic [OUT_W-1:0] er;
        logic             eo;
        int               ec;
        int               ra, rn, rm;

        tbl[0]  = '{a: 3,   n: 5,   mode: 0, res: 243,      ovf: 0, cyc: 5};
        tbl[1]  = '{a: 3,   n: 5,   mode: 1, res: 243,      ovf: 0, cyc: 3};
        tbl[2]  = '{a: 0,   n: 0,   mode: 0, res: 1,        ovf: 0, cyc: 0};
        tbl[3]  = '{a: 0,   n: 0,   mode: 1, res: 1,        ovf: 0, cyc: 0};
        tbl[4]  = '{a: 0,   n: 7,   mode: 0, res: 0,        ovf: 0, cyc: 7};
        tbl[5]  = '{a: 0,   n: 7,   mode: 1, res: 0,        ovf: 0, cyc: 3};
        tbl[6]  = '{a: 2,   n: 16,  mode: 1, res: RES_2_16, ovf: 1, cyc: 5};
        tbl[7]  = '{a: 2,   n: 16,  mode: 0, res: RES_2_16, ovf: 1, cyc: 16};
        tbl[8]  = '{a: 2,   n: 15,  mode: 1, res: 32768,    ovf: 0, cyc: 4};
        tbl[9]  = '{a: 255, n: 2,   mode: 1, res: 65025,    ovf: 0, cyc: 2};
        tbl[10] = '{a: 1,   n: 255, mode: 0, res: 1,        ovf: 0, cyc: 255};
        tbl[11] = '{a: 9,   n: 0,   mode: 1, res: 1,        ovf: 0, cyc: 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", busy_o, 0);
        chk("reset.done", done_o, 0);
        chk("reset.result", result_o, 0);
        chk("reset.ovf", ovf_o, 0);
        chk("reset.cycles", cycles_o, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++)
            do_req(tbl[i].a, tbl[i].n, tbl[i].mode, tbl[i].res, tbl[i].ovf, tbl[i].cyc,
                   $sformatf("tbl%0d", i));

        // Reset in the middle of a long linear run
        @(negedge clk);
        a_i = 3; n_i = 200; mode_i = 0; go_i = 1'b1;
        @(posedge clk); #1;
        go_i = 1'b0;
        repeat (49) @(posedge clk);
        #2;
        chk("midrst.busy_before", busy_o, 1);
        rst = 1'b0;
        #1;
        chk("midrst.busy", busy_o, 0);
        chk("midrst.done", done_o, 0);
        chk("midrst.result", result_o, 0);
        chk("midrst.ovf", ovf_o, 0);
        chk("midrst.cycles", cycles_o, 0);
        @(negedge clk);
        rst = 1'b1;
        do_req(5, 2, 0, 25, 0, 2, "after_rst");

        // go_i held high through DONE must not retrigger
        begin
            int lat;
            @(negedge clk);
            a_i = 3; n_i = 2; mode_i = 0; go_i = 1'b1;
            lat = 0;
            @(posedge clk); #1;
            while (!done_o && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("hold.done", done_o, 1);
            chk("hold.latency", lat, 3);
            a_i = 7; n_i = 9;
            repeat (5) @(posedge clk);
            #1;
            chk("hold.still_done", done_o, 1);
            chk("hold.no_busy", busy_o, 0);
            chk("hold.result", result_o, 9);
            @(negedge clk);
            go_i = 1'b0;
            @(posedge clk); #1;
            chk("hold.idle", done_o, 0);
            chk("hold.idle_busy", busy_o, 0);
            chk("hold.kept_result", result_o, 9);
            chk("hold.kept_cycles", cycles_o, 2);
        end

        // Randomized requests against the reference model
        for (int k = 0; k < 40; k++) begin
            ra = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 255));
            rn = int'($urandom_range(0, 255));
            rm = int'($urandom_range(0, 1));
            model(ra, rn, rm, er, eo, ec);
            do_req(IN_W'(ra), IN_W'(rn), 1'(rm), er, eo, ec,
                   $sformatf("rnd%0d_a%0d_n%0d_m%0d", k, ra, rn, rm));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
